imem_loader: RTL
================

Name: imem_loader

Overview:
- Byte-stream program loader. It is the write-side counterpart of the instruction memory read port.
- Accepts a length-prefixed byte stream (for example from a UART receiver) over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and drives a synchronous write port into instruction memory at consecutive word addresses from 0.
- Holds the CPU in reset (cpu_hold) while a load is in progress.

Parameters:
- ADDR_W, 9, width of the instruction-memory word address.
- DEPTH, 512, number of writable words; a header count above DEPTH is an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle when in_valid=1.
- mem_we  output  1  write strobe to instruction memory, one cycle per word.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  word to write.
- busy  output  1  high in HDR0, HDR1, DATA.
- cpu_hold  output  1  equals busy; keeps the CPU in reset during a load.
- done  output  1  sticky; set on successful completion, cleared by start.
- err  output  1  sticky; set on a bad header, cleared by start.
- words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err, words_loaded.
  - Byte index, header and assembly registers are cleared.
  - Memory contents are not touched; a partial load is left as written.
- A byte is accepted on a rising clk edge where in_valid && in_ready. in_ready is combinational from state only: it is 1 in HDR0, HDR1 and DATA, else 0.
- States:
  - IDLE: on start → HDR0. Clear done, err and words_loaded.
  - HDR0: on accept, latch count[15:8] → HDR1.
  - HDR1: on accept, latch count[7:0], forming N. Then:
    - N=0 → DONE.
    - N>DEPTH → ERR.
    - otherwise → DATA, with byte index 0 and word address 0.
  - DATA: each accepted byte shifts into the assembly register, MSB first (first byte → bits 31:24). When the 4th byte is accepted:
    - Next cycle: mem_we=1, mem_wdata=assembled word, mem_addr=current word address.
    - Word address and words_loaded then increment.
    - If the word just written is word N-1, go to DONE in the same cycle mem_we is high.
  - DONE: done=1, busy=0. Ignore in_valid. On start, behave as IDLE.
  - ERR: err=1, busy=0, no writes. On start, behave as IDLE.
- Write latency: mem_we asserts exactly 1 cycle after acceptance of a word's 4th byte, and lasts exactly 1 cycle.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Full throughput is required: a byte may be accepted in the same cycle mem_we is high for the previous word, so sustained 1 byte/cycle input must work.
- start while busy: ignored, with no restart and no flag change.
- in_valid outside HDR0/HDR1/DATA: ignored, since in_ready=0.
- Width rules: N is 16 bits, compared against DEPTH unsigned. mem_addr never wraps, because N ≤ DEPTH guarantees the last address is DEPTH-1.
- Stream ending mid-word: the loader stays in DATA with busy=1. There is no timeout; only reset or completion exits.
- Reset mid-load: immediate return to IDLE. cpu_hold drops with reset.

Decomposition:
- Shared package holds:
  - state enum: IDLE, HDR0, HDR1, DATA, DONE, ERR.
  - BYTES_PER_WORD = 4.
  - HDR_BYTES = 2.
- One natural sub-module: byte_packer, a 4-byte shift register with byte index and word_valid pulse, reusable for a future data-memory loader.
- FSM, address counter and header logic stay in imem_loader.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 00 03 | 20 08 00 05 | 20 09 00 03 | 01 09 50 20 at 1 byte/cycle.
  - Required: three mem_we pulses writing addr0=0x20080005, addr1=0x20090003, addr2=0x01095020; done=1, words_loaded=3, busy low after the last write.
- Bursty input:
  - Stimulus: same stream with random in_valid gaps of 0–5 cycles.
  - Required: identical writes; each mem_we exactly 1 cycle after its 4th byte is accepted.
- Header edge cases:
  - Stimulus: header 00 00.
  - Required: DONE with no mem_we.
  - Stimulus: header 02 01 (N=513).
  - Required: err=1, no mem_we, in_ready=0 afterwards.
  - Stimulus: header 02 00 with 2048 bytes.
  - Required: last write at addr 511, done=1.
- Start during load:
  - Stimulus: start pulse while in DATA.
  - Required: ignored; load completes normally.
  - Stimulus: new start from DONE.
  - Required: done clears, a second load writes from addr 0.
- Reset mid-load:
  - Stimulus: assert reset asynchronously (off clock edge) after 6 data bytes.
  - Required: all outputs 0 immediately; only addr0 was written; a subsequent start and full stream load correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    DONE,
    ERR
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned HDR_W          = HDR_BYTES * BYTE_W;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first accepted byte lands in the MSBs,
// completed word is held and flagged with a one-cycle word_valid pulse.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_done_c,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WORD_W-1:0]        word_q, word_d;
  logic                     word_valid_q, word_valid_d;

  assign word_done_c = accept && !clr && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d      = shift_q;
    idx_d        = idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (accept) begin
      if (word_done_c) begin
        word_d       = {shift_q, in_byte};
        word_valid_d = 1'b1;
        idx_d        = '0;
      end else begin
        shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], in_byte};
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader writing 32-bit words into instruction
// memory from address 0 while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = HDR_W + 1;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   hdr_hi_q, hdr_hi_d;
  logic [HDR_W-1:0]    n_q, n_d;
  logic [HDR_W-1:0]    n_c;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                accept_c;
  logic                pk_clr_c;
  logic                word_done_c;
  logic [WORD_W-1:0]   pk_word;
  logic                pk_valid;

  assign n_c      = {hdr_hi_q, in_data};
  assign accept_c = in_valid && (state_q == DATA);

  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (reset),
    .clr         (pk_clr_c),
    .accept      (accept_c),
    .in_byte     (in_data),
    .word_done_c (word_done_c),
    .word        (pk_word),
    .word_valid  (pk_valid)
  );

  // Next-state, header capture and write-address bookkeeping.
  always_comb begin
    state_d    = state_q;
    hdr_hi_d   = hdr_hi_q;
    n_d        = n_q;
    words_d    = words_q;
    mem_addr_d = mem_addr_q;
    pk_clr_c   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = HDR0;
          words_d  = '0;
          pk_clr_c = 1'b1;
        end
      end
      HDR0: begin
        if (in_valid) begin
          hdr_hi_d = in_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (in_valid) begin
          n_d      = n_c;
          pk_clr_c = 1'b1;
          if (n_c == '0) begin
            state_d = DONE;
          end else if ({1'b0, n_c} > CMP_W'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Address of the next write is the count of words already written.
        if (word_done_c) begin
          mem_addr_d = words_q[ADDR_W-1:0];
          words_d    = words_q + CNT_W'(1);
          if (HDR_W'(words_q) + HDR_W'(1) == n_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hdr_hi_q   <= '0;
      n_q        <= '0;
      words_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      n_q        <= n_d;
      words_q    <= words_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign busy         = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
  assign in_ready     = busy;
  assign cpu_hold     = busy;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign mem_we       = pk_valid;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = pk_word;
  assign words_loaded = words_q;

endmodule
